// File: rtl/mtr_drv_if.sv
// mtr_drv_if: command and PWM bundle between the motor-drive stage and its
// upstream controller. The master side drives enable/speed commands and
// observes the H-bridge legs; the slave side is the drive stage itself.
interface mtr_drv_if;
    logic               en;
    logic signed [10:0] lft_spd;
    logic signed [10:0] rght_spd;
    logic               lft_pwm1;
    logic               lft_pwm2;
    logic               rght_pwm1;
    logic               rght_pwm2;
    logic               pwm_synch;

    modport master (
        output en, lft_spd, rght_spd,
        input  lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2, pwm_synch
    );

    modport slave (
        input  en, lft_spd, rght_spd,
        output lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2, pwm_synch
    );
endinterface

// File: rtl/mtr_drv.sv
// mtr_drv: dual H-bridge PWM stage with dead-time, per-period double-buffered
// duty and a period-start strobe for current sampling.
// Optional feature: define SLEW_LIMIT_EN to bound the per-period duty change
// to MAX_STEP; without it the duty jumps straight to the commanded target.
module mtr_drv #(
    parameter logic [10:0] NONOVERLAP = 11'h040
`ifdef SLEW_LIMIT_EN
    ,
    parameter logic [10:0] MAX_STEP   = 11'd32
`endif
) (
    input  logic      clk,
    input  logic      rst,
    mtr_drv_if.slave  bus
);

    localparam logic [10:0] DUTY_MID = 11'd1024;
    localparam logic [10:0] CNT_LAST = 11'h7FF;

    logic [10:0] cnt_q, cnt_d;
    logic [10:0] lft_duty_q, lft_duty_d;
    logic [10:0] rght_duty_q, rght_duty_d;
    logic        lft_pwm1_q, lft_pwm1_d;
    logic        lft_pwm2_q, lft_pwm2_d;
    logic        rght_pwm1_q, rght_pwm1_d;
    logic        rght_pwm2_q, rght_pwm2_d;
    logic        pwm_synch_q, pwm_synch_d;

    logic [10:0] lft_tgt, rght_tgt;
    logic [10:0] lft_load, rght_load;

`ifdef SLEW_LIMIT_EN
    // Move duty toward tgt by at most MAX_STEP; lands exactly on tgt when close.
    function automatic logic [10:0] slew(input logic [10:0] duty, input logic [10:0] tgt);
        logic signed [11:0] diff;
        logic signed [11:0] lim;
        logic signed [11:0] step;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, duty});
        lim  = $signed({1'b0, MAX_STEP});
        if (diff > lim)
            step = lim;
        else if (diff < -lim)
            step = -lim;
        else
            step = diff;
        return 11'($signed({1'b0, duty}) + step);
    endfunction
`endif

    // Offset-binary target (spd + 1024) and the duty value to load at the boundary.
    always_comb begin
        lft_tgt  = {~bus.lft_spd[10], bus.lft_spd[9:0]};
        rght_tgt = {~bus.rght_spd[10], bus.rght_spd[9:0]};
`ifdef SLEW_LIMIT_EN
        lft_load  = slew(lft_duty_q, lft_tgt);
        rght_load = slew(rght_duty_q, rght_tgt);
`else
        lft_load  = lft_tgt;
        rght_load = rght_tgt;
`endif
    end

    // Free-running period counter and duty double-buffer; coast forces mid duty.
    always_comb begin
        cnt_d       = cnt_q + 11'd1;
        lft_duty_d  = lft_duty_q;
        rght_duty_d = rght_duty_q;
        if (!bus.en) begin
            lft_duty_d  = DUTY_MID;
            rght_duty_d = DUTY_MID;
        end else if (cnt_q == CNT_LAST) begin
            lft_duty_d  = lft_load;
            rght_duty_d = rght_load;
        end
    end

    // Leg compares with dead-time on both edges; pwm2 compare is 12-bit so it never wraps.
    always_comb begin
        lft_pwm1_d  = bus.en && (cnt_q >= NONOVERLAP) && (cnt_q < lft_duty_q);
        lft_pwm2_d  = bus.en && ({1'b0, cnt_q} >= ({1'b0, lft_duty_q} + {1'b0, NONOVERLAP}));
        rght_pwm1_d = bus.en && (cnt_q >= NONOVERLAP) && (cnt_q < rght_duty_q);
        rght_pwm2_d = bus.en && ({1'b0, cnt_q} >= ({1'b0, rght_duty_q} + {1'b0, NONOVERLAP}));
        pwm_synch_d = (cnt_q == CNT_LAST);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            lft_duty_q  <= DUTY_MID;
            rght_duty_q <= DUTY_MID;
            lft_pwm1_q  <= 1'b0;
            lft_pwm2_q  <= 1'b0;
            rght_pwm1_q <= 1'b0;
            rght_pwm2_q <= 1'b0;
            pwm_synch_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            lft_duty_q  <= lft_duty_d;
            rght_duty_q <= rght_duty_d;
            lft_pwm1_q  <= lft_pwm1_d;
            lft_pwm2_q  <= lft_pwm2_d;
            rght_pwm1_q <= rght_pwm1_d;
            rght_pwm2_q <= rght_pwm2_d;
            pwm_synch_q <= pwm_synch_d;
        end
    end

    assign bus.lft_pwm1  = lft_pwm1_q;
    assign bus.lft_pwm2  = lft_pwm2_q;
    assign bus.rght_pwm1 = rght_pwm1_q;
    assign bus.rght_pwm2 = rght_pwm2_q;
    assign bus.pwm_synch = pwm_synch_q;

endmodule

// File: tb/tb_mtr_drv.sv
// tb_mtr_drv: scoreboard bench. The stimulus side tracks the drive at period
// granularity (which duty each period uses, over which counter span enable
// was high) and pushes expected per-period leg on-times; the monitor measures
// on-times between pwm_synch strobes and compares.
module tb_mtr_drv;
    localparam int PER = 2048;
    localparam int NOV = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mtr_drv_if bus();

    mtr_drv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int l1;
        int l2;
        int r1;
        int r2;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done  = 1'b0;

    int cur_en, cur_l, cur_r;
    int m_cnt, m_dl, m_dr, m_en_lo, m_en_hi, m_pd_l, m_pd_r;
    bit m_en_seen;

    function automatic int ov(int a, int b, int lo, int hi);
        int x;
        int y;
        x = (a > lo) ? a : lo;
        y = (b < hi) ? b : hi;
        return (y > x) ? (y - x) : 0;
    endfunction

    function automatic int load(int duty, int spd);
        int tgt;
        int d;
        tgt = spd + 1024;
        d   = tgt - duty;
`ifdef SLEW_LIMIT_EN
        if (d > 32)  d = 32;
        if (d < -32) d = -32;
`endif
        return duty + d;
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        exp_t e;
        bus.en       = cur_en[0];
        bus.lft_spd  = 11'(cur_l);
        bus.rght_spd = 11'(cur_r);
        @(posedge clk);
        if (cur_en != 0) begin
            if (!m_en_seen) begin
                m_en_seen = 1'b1;
                m_en_lo   = m_cnt;
                m_pd_l    = m_dl;
                m_pd_r    = m_dr;
            end
            m_en_hi = m_cnt + 1;
        end
        if (cur_en == 0) begin
            m_dl = 1024;
            m_dr = 1024;
        end else if (m_cnt == PER - 1) begin
            m_dl = load(m_dl, cur_l);
            m_dr = load(m_dr, cur_r);
        end
        if (m_cnt == PER - 1) begin
            if (m_en_seen) begin
                e.l1 = ov(NOV, m_pd_l, m_en_lo, m_en_hi);
                e.l2 = ov(m_pd_l + NOV, PER, m_en_lo, m_en_hi);
                e.r1 = ov(NOV, m_pd_r, m_en_lo, m_en_hi);
                e.r2 = ov(m_pd_r + NOV, PER, m_en_lo, m_en_hi);
            end else begin
                e.l1 = 0; e.l2 = 0; e.r1 = 0; e.r2 = 0;
            end
            sb.push_back(e);
            m_en_seen = 1'b0;
        end
        m_cnt = (m_cnt + 1) % PER;
        @(negedge clk);
    endtask

    task automatic run_cycles(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(int c);
        do step(); while (m_cnt != c);
    endtask

    // Monitor: measure each period's leg on-times and compare with the scoreboard.
    initial begin
        int   ns, h_l1, h_l2, h_r1, h_r2;
        bit   ovl;
        exp_t e;
        ns = 0; h_l1 = 0; h_l2 = 0; h_r1 = 0; h_r2 = 0; ovl = 1'b0;
        @(posedge clk); #1;
        check("rst_outputs", int'({bus.lft_pwm1, bus.lft_pwm2, bus.rght_pwm1,
                                   bus.rght_pwm2, bus.pwm_synch}), 0);
        wait (rst == 1'b0);
        forever begin
            @(posedge clk); #1;
            if (done) break;
            ns++;
            h_l1 += int'(bus.lft_pwm1);
            h_l2 += int'(bus.lft_pwm2);
            h_r1 += int'(bus.rght_pwm1);
            h_r2 += int'(bus.rght_pwm2);
            if ((bus.lft_pwm1 && bus.lft_pwm2) || (bus.rght_pwm1 && bus.rght_pwm2))
                ovl = 1'b1;
            if (bus.pwm_synch) begin
                check("synch_period", ns, PER);
                check("leg_overlap", int'(ovl), 0);
                check("sb_has_entry", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("lft_pwm1_on", h_l1, e.l1);
                    check("lft_pwm2_on", h_l2, e.l2);
                    check("rght_pwm1_on", h_r1, e.r1);
                    check("rght_pwm2_on", h_r2, e.r2);
                end
                ns = 0; h_l1 = 0; h_l2 = 0; h_r1 = 0; h_r2 = 0; ovl = 1'b0;
            end else if (ns > 2 * PER) begin
                check("synch_timeout", ns, PER);
                ns = 0; h_l1 = 0; h_l2 = 0; h_r1 = 0; h_r2 = 0; ovl = 1'b0;
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized speed changes.
    initial begin
        cur_en = 0; cur_l = 0; cur_r = 0;
        bus.en = 1'b0; bus.lft_spd = '0; bus.rght_spd = '0;
        m_cnt = 0; m_dl = 1024; m_dr = 1024; m_en_seen = 1'b0;
        m_en_lo = 0; m_en_hi = 0; m_pd_l = 1024; m_pd_r = 1024;
        repeat (5) @(negedge clk);
        rst = 1'b0;

        run_cycles(2 * PER);

        cur_en = 1;
        run_cycles(2 * PER);

        run_to(700);
        cur_l = 1023; cur_r = -1024;
        run_to(0);
        run_cycles(PER);

        cur_l = 0; cur_r = 0;
        run_cycles(PER);
        run_to(500);
        cur_r = 200;
        run_to(0);
        run_cycles(PER);

        cur_r = 0; cur_l = 500;
        run_cycles(17 * PER);

        cur_l = 400;
        run_cycles(PER);
        run_to(300);
        cur_en = 0;
        run_to(0);
        run_to(1000);
        cur_en = 1;
        run_to(0);
        run_cycles(2 * PER);

        repeat (4) begin
            run_to(int'($urandom_range(1, PER - 1)));
            cur_l = int'($urandom_range(0, 2047)) - 1024;
            cur_r = int'($urandom_range(0, 2047)) - 1024;
        end
        run_to(0);
        run_cycles(PER);

        repeat (3) step();
        done = 1'b1;
        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mtr_drv.md
# mtr_drv

Motor-drive PWM stage sitting directly downstream of the heading PID controller. It converts the signed 11-bit left/right speed commands into complementary, dead-time-protected H-bridge PWM pairs, one pair per motor, from a shared free-running 11-bit period counter. It also emits a period-synchronous strobe for downstream current/A2D sampling. Duty is double-buffered per period, and an optional slew limiter bounds the per-period duty change.

## Interface
- NONOVERLAP, 11'h040: dead-time in clk cycles between one H-bridge leg turning off and the other turning on.
- MAX_STEP, 11'd32: maximum duty change per PWM period; used only when SLEW_LIMIT_EN is defined.

- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  drive enable; low = coast.
- lft_spd  input  11  signed left speed command, range -1024..+1023.
- rght_spd  input  11  signed right speed command, same range.
- lft_pwm1  output  1  left forward leg, registered.
- lft_pwm2  output  1  left reverse leg, registered.
- rght_pwm1  output  1  right forward leg, registered.
- rght_pwm2  output  1  right reverse leg, registered.
- pwm_synch  output  1  one-cycle period-start strobe, registered.

## Operation
- cnt: 11-bit unsigned counter, increments every cycle and wraps 2047 -> 0. Period = 2048 cycles. It runs regardless of en.
- Per-side target: tgt = spd + 1024, computed as an offset-binary unsigned 11-bit value. The range is 0..2047, so the sum never overflows. spd = 0 gives 50% locked-antiphase (zero net torque).
- Per-side duty register (11 bits) loads only on the edge where cnt == 2047, so each new period starts with the new duty. Input changes mid-period have no effect until the next boundary.
- Leg generation, evaluated from pre-edge cnt/duty and registered:
  - pwm1 <= en && cnt >= NONOVERLAP && cnt < duty.
  - pwm2 <= en && {1'b0,cnt} >= {1'b0,duty} + NONOVERLAP. The comparison is 12-bit, with no wrap.
- Resulting on-times per period:
  - pwm1: max(duty - NONOVERLAP, 0) cycles.
  - pwm2: max(2048 - duty - NONOVERLAP, 0) cycles.
- pwm1 and pwm2 of the same side are never high in the same cycle, for any duty value.
- pwm_synch <= (cnt == 2047). It is high exactly during the cycle in which cnt == 0.
- en low:
  - All four pwm outputs go 0 at the next edge.
  - Both duty registers are forced to 1024 every cycle en is low.
  - pwm_synch continues.
- en rising: duty stays 1024 until the next period boundary, then loads per the normal rule (slew-limited if enabled).

## Timing
- Reset values: cnt = 0, duty = 1024 (both sides), all outputs 0.
- Reset is asynchronous. Assertion mid-period clears everything immediately. After deassertion the counter restarts at 0, and the first pwm_synch pulse occurs 2048 cycles later.
- Latency, command to effect: the command is sampled at the cnt == 2047 edge. pwm1 first reflects the new duty NONOVERLAP+1 cycles into the period.
- en to output: 1 cycle.
- Simultaneous events:
  - en low takes priority over the duty load at cnt == 2047.
  - rst takes priority over everything.

## Configuration
- SLEW_LIMIT_EN defined:
  - At each period boundary, duty_new = duty + clamp(tgt - duty, -MAX_STEP, +MAX_STEP).
  - The difference is computed as a signed 12-bit value.
  - When |tgt - duty| <= MAX_STEP, duty_new = tgt exactly (no overshoot).
  - en low resets duty to 1024, so re-enable ramps from zero speed.
- SLEW_LIMIT_EN undefined:
  - duty_new = tgt at each boundary.
  - MAX_STEP is unused.

## Test plan
- Reset, then deassert with en = 0: all outputs 0; pwm_synch pulses every 2048 cycles, first pulse 2048 cycles after deassertion.
- en = 1, lft_spd = 0: lft_pwm1 high 960 cycles (cnt 64..1023), lft_pwm2 high 960 cycles (cnt 1088..2047), each once per period; the two legs never overlap.
- lft_spd = +1023 / rght_spd = -1024, macro off:
  - lft_pwm1 high 1983 cycles, lft_pwm2 never high.
  - rght_pwm1 never high, rght_pwm2 high 1984 cycles.
- Change rght_spd 0 -> +200 at cnt = 500: the current period keeps 960-cycle pulses; the next period gives rght_pwm1 = 1160, rght_pwm2 = 760.
- SLEW_LIMIT_EN, MAX_STEP = 32, step lft_spd 0 -> +500: duty goes 1056, 1088, … 1504 after 15 boundaries, then 1524 at the 16th and stays. Without the macro, duty = 1524 at the first boundary.
- Drop en at cnt = 300 with lft_spd = +400: outputs 0 one cycle later and duty reads 1024. Re-raise en: the period after the next boundary uses 1424 (macro off) or 1056 (macro on, MAX_STEP = 32).
